// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_pkg
// Brief    : Shared opcodes, responder state and request-type encodings.
// Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

  // Opcodes carried in the top nibble of an instruction word
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_MOVE  = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_DISP  = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b0110;
  localparam logic [3:0] OP_ADDI  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_FETCH = 2'd1,
    REQ_LOAD  = 2'd2,
    REQ_STORE = 2'd3
  } req_t;

  // Resolve simultaneous strobes: store beats load beats fetch
  function automatic req_t decode_req(input logic fetch, input logic load, input logic store);
    if (store) return REQ_STORE;
    if (load)  return REQ_LOAD;
    if (fetch) return REQ_FETCH;
    return REQ_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_if
// Brief    : Strobe/data bundle between the control FSM and the responder.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();
  logic              pc_en;
  logic              ILin;
  logic              _Extern;
  logic              AddrSel;
  logic              MemWr;
  logic [ADDR_W-1:0] addr_x;
  logic [DATA_W-1:0] wdata;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] instr;
  logic [3:0]        operation;
  logic [ADDR_W-1:0] pc;
  logic              mem_ready;
  logic              err;

  // FSM / loader side
  modport master (
    output pc_en, ILin, _Extern, AddrSel, MemWr, addr_x, wdata,
           prog_we, prog_addr, prog_wdata,
    input  rdata, instr, operation, pc, mem_ready, err
  );

  // Memory responder side
  modport slave (
    input  pc_en, ILin, _Extern, AddrSel, MemWr, addr_x, wdata,
           prog_we, prog_addr, prog_wdata,
    output rdata, instr, operation, pc, mem_ready, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_ram
// Brief    : Unified instruction/data RAM, one sync write, two async reads.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Single synchronous write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Services fetch/load/store strobes with optional wait states,
//            owns PC and instruction register, flags protocol errors.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYC);

  logic              fetch_req, load_req, store_req;
  logic              partial_fetch, conflict, type_change;
  logic              mem_ready, commit_fetch, commit_store, prog_ok, ram_we;
  req_t              req, pend_q, pend_nx;
  state_t            state_q, state_nx;
  logic [3:0]        cnt_q, cnt_nx, held_cnt;
  logic [ADDR_W-1:0] pc_q, ram_waddr;
  logic [DATA_W-1:0] instr_q, ram_wdata, pc_word;

  // Decode strobes into one prioritised request and detect protocol errors
  always_comb begin
    fetch_req     = bus.pc_en & bus.ILin;
    partial_fetch = bus.pc_en ^ bus.ILin;
    load_req      = bus.AddrSel & bus._Extern & ~bus.MemWr;
    store_req     = bus.AddrSel & bus.MemWr;
    conflict      = (fetch_req & (load_req | store_req)) | (load_req & store_req);
    req           = decode_req(fetch_req, load_req, store_req);
    // A request only accumulates wait cycles while the same type is held
    held_cnt      = (state_q == ST_WAIT && req == pend_q) ? cnt_q : 4'd0;
    type_change   = (state_q == ST_WAIT) && (req != REQ_NONE) && (req != pend_q);
    mem_ready     = (req != REQ_NONE) && (held_cnt == WAIT_LIM);
    commit_fetch  = mem_ready && (req == REQ_FETCH) && !reset;
    commit_store  = mem_ready && (req == REQ_STORE) && !reset;
    prog_ok       = bus.prog_we && (state_q == ST_IDLE) && (req == REQ_NONE) && !reset;
    ram_we        = commit_store | prog_ok;
    ram_waddr     = commit_store ? bus.addr_x : bus.prog_addr;
    ram_wdata     = commit_store ? bus.wdata  : bus.prog_wdata;
  end

  // Next state: commit or drop returns to IDLE, otherwise keep counting
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    pend_nx  = pend_q;
    if (req == REQ_NONE || mem_ready) begin
      state_nx = ST_IDLE;
      cnt_nx   = 4'd0;
      pend_nx  = REQ_NONE;
    end else begin
      state_nx = ST_WAIT;
      cnt_nx   = held_cnt + 4'd1;
      pend_nx  = req;
    end
  end

  // State, PC, instruction register and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= REQ_NONE;
      pc_q    <= '0;
      instr_q <= '0;
      bus.err <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      pend_q  <= pend_nx;
      if (commit_fetch) begin
        instr_q <= pc_word;
        pc_q    <= pc_q + ADDR_W'(1);
      end
      if (partial_fetch | conflict | type_change) bus.err <= 1'b1;
    end
  end

  mem_responder_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (pc_q),
    .rdata_a (pc_word),
    .raddr_b (bus.addr_x),
    .rdata_b (bus.rdata)
  );

  assign bus.mem_ready = mem_ready;
  assign bus.instr     = instr_q;
  assign bus.operation = instr_q[DATA_W-1 -: 4];
  assign bus.pc        = pc_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Drives three responders (0, 2 and 3 wait cycles) with the same
//            strobes and compares each against a request-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
  logic clk, reset;
  logic pc_en, ILin, extern_s, AddrSel, MemWr, prog_we;
  logic [7:0]  addr_x, prog_addr;
  logic [15:0] wdata, prog_wdata;

  logic [15:0] o_rdata [3];
  logic [15:0] o_instr [3];
  logic [3:0]  o_op    [3];
  logic [7:0]  o_pc    [3];
  logic        o_rdy   [3];
  logic        o_err   [3];

  int checks = 0;
  int errors = 0;

  // Model state: one copy per responder
  int          wc [3] = '{0, 2, 3};
  logic [15:0] m_mem [3][256];
  logic [7:0]  m_pc [3];
  logic [15:0] m_instr [3];
  logic        m_err [3];
  int          m_run [3];   // cycles the pending request has already been held
  int          m_type [3];  // 1 fetch, 2 load, 3 store

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus ();
    assign bus.pc_en      = pc_en;
    assign bus.ILin       = ILin;
    assign bus._Extern    = extern_s;
    assign bus.AddrSel    = AddrSel;
    assign bus.MemWr      = MemWr;
    assign bus.addr_x     = addr_x;
    assign bus.wdata      = wdata;
    assign bus.prog_we    = prog_we;
    assign bus.prog_addr  = prog_addr;
    assign bus.prog_wdata = prog_wdata;
    mem_responder #(
      .DATA_W(16), .ADDR_W(8), .WAIT_CYC(k == 0 ? 0 : (k == 1 ? 2 : 3))
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
    assign o_rdata[k] = bus.rdata;
    assign o_instr[k] = bus.instr;
    assign o_op[k]    = bus.operation;
    assign o_pc[k]    = bus.pc;
    assign o_rdy[k]   = bus.mem_ready;
    assign o_err[k]   = bus.err;
  end

  always #5 clk = ~clk;

  function automatic int cur_req();
    if (AddrSel && MemWr) return 3;
    if (AddrSel && extern_s) return 2;
    if (pc_en && ILin) return 1;
    return 0;
  endfunction

  // A request completes once it has been held for its wait count of earlier cycles
  function automatic bit exp_ready(int k);
    int r = cur_req();
    int held = (m_run[k] > 0 && m_type[k] == r) ? m_run[k] : 0;
    return (r != 0) && (held == wc[k]);
  endfunction

  // Reference model update at each rising edge
  always @(posedge clk) begin
    int r, held, nreq;
    r = cur_req();
    nreq = int'(pc_en && ILin) + int'(AddrSel && extern_s && !MemWr) + int'(AddrSel && MemWr);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_pc[k] = 0; m_instr[k] = 0; m_err[k] = 0; m_run[k] = 0; m_type[k] = 0;
      end else begin
        held = (m_run[k] > 0 && m_type[k] == r) ? m_run[k] : 0;
        if ((pc_en != ILin) || nreq >= 2 || (m_run[k] > 0 && r != 0 && r != m_type[k]))
          m_err[k] = 1;
        if (r == 0) begin
          if (prog_we && m_run[k] == 0) m_mem[k][prog_addr] = prog_wdata;
          m_run[k] = 0;
        end else if (held == wc[k]) begin
          if (r == 1) begin
            m_instr[k] = m_mem[k][m_pc[k]];
            m_pc[k] = m_pc[k] + 8'd1;
          end else if (r == 3) begin
            m_mem[k][addr_x] = wdata;
          end
          m_run[k] = 0;
        end else begin
          m_run[k] = held + 1;
          m_type[k] = r;
        end
      end
    end
  end

  task automatic clear_strobes();
    pc_en = 0; ILin = 0; extern_s = 0; AddrSel = 0; MemWr = 0; prog_we = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1; clear_strobes();
    @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_pc[k] !== 8'h00) begin errors++; $display("FAIL reset_pc[%0d]: got %h expected 00", k, o_pc[k]); end
      checks++; if (o_instr[k] !== 16'h0000) begin errors++; $display("FAIL reset_instr[%0d]: got %h expected 0000", k, o_instr[k]); end
      checks++; if (o_op[k] !== 4'h0) begin errors++; $display("FAIL reset_op[%0d]: got %h expected 0", k, o_op[k]); end
      checks++; if (o_err[k] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", k, o_err[k]); end
      checks++; if (o_rdy[k] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, o_rdy[k]); end
    end
  endtask

  task automatic preload();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      prog_we = 1; prog_addr = 8'(a);
      prog_wdata = (a == 0) ? 16'h3012 : (a == 1) ? 16'h5000 : 16'($urandom);
    end
    @(negedge clk); prog_we = 0;
  endtask

  task automatic test_fetch_single();
    do_reset();
    pc_en = 1; ILin = 1; #1;
    checks++; if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL fetch1_ready: got %b expected 1", o_rdy[0]); end
    checks++; if (o_rdy[1] !== 1'b0) begin errors++; $display("FAIL fetch1_ready_w2: got %b expected 0", o_rdy[1]); end
    @(negedge clk); clear_strobes(); #1;
    checks++; if (o_instr[0] !== 16'h3012) begin errors++; $display("FAIL fetch1_instr: got %h expected 3012", o_instr[0]); end
    checks++; if (o_op[0] !== 4'b0011) begin errors++; $display("FAIL fetch1_op: got %b expected 0011", o_op[0]); end
    checks++; if (o_pc[0] !== 8'h01) begin errors++; $display("FAIL fetch1_pc: got %h expected 01", o_pc[0]); end
    @(negedge clk); #1;
    checks++; if (o_pc[2] !== 8'h00) begin errors++; $display("FAIL drop_pc_w3: got %h expected 00", o_pc[2]); end
    checks++; if (o_err[2] !== 1'b0) begin errors++; $display("FAIL drop_err_w3: got %b expected 0", o_err[2]); end
    checks++; if (o_instr[2] !== 16'h0000) begin errors++; $display("FAIL drop_instr_w3: got %h expected 0000", o_instr[2]); end
  endtask

  task automatic test_fetch_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      pc_en = 1; ILin = 1; #1;
      checks++; if (o_rdy[1] !== (i == 2)) begin errors++; $display("FAIL wait_ready step %0d: got %b expected %b", i, o_rdy[1], i == 2); end
      checks++; if (o_pc[1] !== 8'h00) begin errors++; $display("FAIL wait_pc_early step %0d: got %h expected 00", i, o_pc[1]); end
    end
    @(negedge clk); clear_strobes(); #1;
    checks++; if (o_pc[1] !== 8'h01) begin errors++; $display("FAIL wait_pc: got %h expected 01", o_pc[1]); end
    checks++; if (o_instr[1] !== 16'h3012) begin errors++; $display("FAIL wait_instr: got %h expected 3012", o_instr[1]); end
    checks++; if (o_pc[0] !== 8'h03) begin errors++; $display("FAIL held_fetch_w0_pc: got %h expected 03", o_pc[0]); end
    @(negedge clk); #1;
    checks++; if (o_pc[1] !== 8'h01) begin errors++; $display("FAIL wait_no_double: got %h expected 01", o_pc[1]); end
  endtask

  task automatic test_store_load();
    do_reset();
    AddrSel = 1; MemWr = 1; addr_x = 8'h40; wdata = 16'hBEEF;
    repeat (3) @(negedge clk);
    @(negedge clk); MemWr = 0; extern_s = 1; #1;
    checks++; if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", o_rdy[0]); end
    checks++; if (o_rdata[0] !== 16'hBEEF) begin errors++; $display("FAIL load_rdata: got %h expected beef", o_rdata[0]); end
    checks++; if (o_rdata[2] !== 16'hBEEF) begin errors++; $display("FAIL load_rdata_w3: got %h expected beef", o_rdata[2]); end
    @(negedge clk); clear_strobes(); #1;
    checks++; if (o_err[0] !== 1'b0) begin errors++; $display("FAIL store_load_err: got %b expected 0", o_err[0]); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    pc_en = 1; ILin = 1;
    repeat (254) @(negedge clk);
    @(negedge clk); clear_strobes(); #1;
    checks++; if (o_pc[0] !== 8'hFF) begin errors++; $display("FAIL wrap_pre_pc: got %h expected ff", o_pc[0]); end
    @(negedge clk); pc_en = 1; ILin = 1;
    @(negedge clk); clear_strobes(); #1;
    checks++; if (o_pc[0] !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h expected 00", o_pc[0]); end
    checks++; if (o_instr[0] !== m_mem[0][255]) begin errors++; $display("FAIL wrap_instr: got %h expected %h", o_instr[0], m_mem[0][255]); end
    checks++; if (o_pc[1] !== m_pc[1]) begin errors++; $display("FAIL wrap_pc_w2: got %h expected %h", o_pc[1], m_pc[1]); end
  endtask

  task automatic test_conflict();
    logic [15:0] w;
    w = 16'($urandom);
    do_reset();
    pc_en = 1; ILin = 1; AddrSel = 1; MemWr = 1; addr_x = 8'h50; wdata = w; #1;
    checks++; if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL conflict_ready: got %b expected 1", o_rdy[0]); end
    @(negedge clk); clear_strobes(); AddrSel = 1; extern_s = 1; #1;
    checks++; if (o_pc[0] !== 8'h00) begin errors++; $display("FAIL conflict_pc: got %h expected 00", o_pc[0]); end
    checks++; if (o_err[0] !== 1'b1) begin errors++; $display("FAIL conflict_err: got %b expected 1", o_err[0]); end
    checks++; if (o_rdata[0] !== w) begin errors++; $display("FAIL conflict_store: got %h expected %h", o_rdata[0], w); end
    @(negedge clk); clear_strobes();
    repeat (3) @(negedge clk); #1;
    checks++; if (o_err[0] !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", o_err[0]); end
    checks++; if (o_err[2] !== 1'b1) begin errors++; $display("FAIL err_sticky_w3: got %b expected 1", o_err[2]); end
    do_reset(); #1;
    checks++; if (o_err[0] !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", o_err[0]); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    pc_en = 1; ILin = 1;
    @(negedge clk);
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; clear_strobes(); #1;
    checks++; if (o_pc[1] !== 8'h00) begin errors++; $display("FAIL midreset_pc_w2: got %h expected 00", o_pc[1]); end
    checks++; if (o_pc[2] !== 8'h00) begin errors++; $display("FAIL midreset_pc_w3: got %h expected 00", o_pc[2]); end
    checks++; if (o_instr[1] !== 16'h0000) begin errors++; $display("FAIL midreset_instr_w2: got %h expected 0000", o_instr[1]); end
    for (int i = 0; i < 4; i++) begin
      addr_x = 8'(i * 61); #1;
      checks++; if (o_rdata[2] !== m_mem[2][addr_x]) begin errors++; $display("FAIL midreset_mem @%h: got %h expected %h", addr_x, o_rdata[2], m_mem[2][addr_x]); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); pc_en = 1; ILin = 1; #1;
      checks++; if (o_rdy[2] !== (i == 3)) begin errors++; $display("FAIL restart_ready step %0d: got %b expected %b", i, o_rdy[2], i == 3); end
    end
    @(negedge clk); clear_strobes();
  endtask

  task automatic test_random();
    int hold = 0;
    int kind;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      if (hold == 0) begin
        clear_strobes();
        kind = $urandom_range(0, 7);
        hold = $urandom_range(1, 5);
        addr_x = 8'($urandom); wdata = 16'($urandom);
        prog_addr = 8'($urandom); prog_wdata = 16'($urandom);
        case (kind)
          1, 2: begin pc_en = 1; ILin = 1; end
          3: begin AddrSel = 1; extern_s = 1; end
          4: begin AddrSel = 1; MemWr = 1; end
          5: if ($urandom_range(0, 1) == 1) pc_en = 1; else ILin = 1;
          6: begin pc_en = 1; ILin = 1; AddrSel = 1; extern_s = 1; MemWr = 1'($urandom_range(0, 1)); end
          7: prog_we = 1;
          default: ;
        endcase
      end
      hold--;
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++; if (o_rdy[k] !== exp_ready(k)) begin errors++; $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", k, c, o_rdy[k], exp_ready(k)); end
        checks++; if (o_rdata[k] !== m_mem[k][addr_x]) begin errors++; $display("FAIL rand_rdata[%0d] cyc %0d: got %h expected %h", k, c, o_rdata[k], m_mem[k][addr_x]); end
        checks++; if (o_pc[k] !== m_pc[k]) begin errors++; $display("FAIL rand_pc[%0d] cyc %0d: got %h expected %h", k, c, o_pc[k], m_pc[k]); end
        checks++; if (o_instr[k] !== m_instr[k]) begin errors++; $display("FAIL rand_instr[%0d] cyc %0d: got %h expected %h", k, c, o_instr[k], m_instr[k]); end
        checks++; if (o_op[k] !== m_instr[k][15:12]) begin errors++; $display("FAIL rand_op[%0d] cyc %0d: got %h expected %h", k, c, o_op[k], m_instr[k][15:12]); end
        checks++; if (o_err[k] !== m_err[k]) begin errors++; $display("FAIL rand_err[%0d] cyc %0d: got %b expected %b", k, c, o_err[k], m_err[k]); end
      end
    end
    @(negedge clk); reset = 0; clear_strobes();
  endtask

  initial begin
    clk = 0; reset = 1;
    clear_strobes();
    addr_x = 0; wdata = 0; prog_addr = 0; prog_wdata = 0;
    test_reset();
    preload();
    test_fetch_single();
    test_fetch_wait();
    test_store_load();
    test_pc_wrap();
    test_conflict();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
